// File: rtl/fifo_byte_packer.sv
// Read-side drain stage for syn_fifo: pulls bytes with a one-cycle read latency and
// packs them little-endian into PACK-byte words; flush releases a partial word.
module fifo_byte_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int OUT_WIDTH  = DATA_WIDTH * PACK,
    parameter int CNT_WIDTH  = $clog2(PACK + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [CNT_WIDTH-1:0]  out_bytes,
    output logic [15:0]           words_out
);

    // Output handshake: a word transfers on a rising edge where out_valid && out_ready.
    // Once out_valid is high, out_data/out_bytes hold until that transfer happens.

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] PACK_C = CNT_WIDTH'(PACK);
    localparam logic [CNT_WIDTH:0]   PACK_W = (CNT_WIDTH + 1)'(PACK);

    state_t               state;
    logic [CNT_WIDTH-1:0] fill_cnt;
    logic                 inflight;
    logic                 flush_pend;

    logic [CNT_WIDTH:0]   occupancy;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 flush_req;
    logic                 accept;

    // Bytes already captured plus the one still landing; reads stop once a word is spoken for.
    assign occupancy = {1'b0, fill_cnt} + (CNT_WIDTH + 1)'(inflight);
    assign cnt_next  = fill_cnt + CNT_WIDTH'(inflight);
    assign flush_req = flush | flush_pend;
    assign accept    = out_valid & out_ready;

    // Gated by rst so no byte is pulled from the FIFO only to be discarded by the reset.
    assign fifo_rd_en = !rst && (state == FILL) && !fifo_empty
                        && (occupancy < PACK_W) && !flush_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            fill_cnt   <= '0;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_bytes  <= '0;
            words_out  <= '0;
        end else begin
            inflight <= fifo_rd_en;

            if (inflight) begin
                fill_cnt <= cnt_next;
                for (int i = 0; i < PACK; i++) begin
                    if (fill_cnt == CNT_WIDTH'(i)) begin
                        out_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_rdata;
                    end
                end
            end

            unique case (state)
                FILL: begin
                    if (inflight && (cnt_next == PACK_C)) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_bytes <= PACK_C;
                    end else if (flush_req && ((fill_cnt != '0) || inflight)) begin
                        // A read still landing must be captured before the word is released.
                        if (inflight || fifo_rd_en) begin
                            state      <= DRAIN;
                            flush_pend <= 1'b1;
                        end else begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_bytes <= fill_cnt;
                        end
                    end else if (flush_req) begin
                        flush_pend <= 1'b0;
                    end
                end

                DRAIN: begin
                    state     <= HOLD;
                    out_valid <= 1'b1;
                    out_bytes <= cnt_next;
                end

                HOLD: begin
                    if (accept) begin
                        state      <= FILL;
                        out_valid  <= 1'b0;
                        out_data   <= '0;
                        out_bytes  <= '0;
                        fill_cnt   <= '0;
                        flush_pend <= 1'b0;
                        words_out  <= words_out + 16'd1;
                    end else if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end

                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Directed bench for fifo_byte_packer with a behavioural syn_fifo model on the read side.
`timescale 1ns/1ps
module tb_fifo_byte_packer;

    localparam int DW = 8;
    localparam int PK = 4;
    localparam int OW = 32;
    localparam int CW = 3;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          flush      = 1'b0;
    logic          out_ready  = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rd_en;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_bytes;
    logic [15:0]   words_out;

    fifo_byte_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_rdata (fifo_rdata),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bytes  (out_bytes),
        .words_out  (words_out)
    );

    always #5 clk = ~clk;

    // FIFO model: bytes src[wr_taken..wr_total-1] enter on the next edge, rdata lands one cycle after rd_en.
    logic [7:0] src [0:255];
    logic [7:0] fq [$];
    int wr_total = 0, wr_taken = 0, rd_cnt = 0, underflow_cnt = 0, cyc = 0;
    int n_checks = 0, n_fail = 0;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() == 0) begin
                underflow_cnt++;
            end else begin
                fifo_rdata <= fq.pop_front();
                rd_cnt++;
            end
        end
        while (wr_taken < wr_total) begin
            fq.push_back(src[wr_taken]);
            wr_taken++;
        end
        fifo_empty <= (fq.size() == 0);
        cyc <= cyc + 1;
    end

    logic [OW-1:0] got_data [$];
    logic [CW-1:0] got_bytes [$];
    int            got_cyc [$];
    logic [7:0]    exp_q [$];
    bit            conc_done;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_bytes.push_back(out_bytes);
            got_cyc.push_back(cyc);
        end
    end

    task automatic clear_got();
        got_data.delete();
        got_bytes.delete();
        got_cyc.delete();
    endtask

    task automatic load_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) src[wr_total + i] = first + 8'(i);
        wr_total += n;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_checks++; if (out_bytes !== 3'd0) begin n_fail++; $display("FAIL reset_out_bytes: got %0d want 0", out_bytes); end
        n_checks++; if (words_out !== 16'd0) begin n_fail++; $display("FAIL reset_words_out: got %0d want 0", words_out); end
        n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (fifo_rd_en !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL idle_after_reset: rd_en %b out_valid %b want 0 0", fifo_rd_en, out_valid);
            end
        end
    endtask

    task automatic test_full_words();
        logic [31:0] exp_w [4];
        exp_w = '{32'h14131211, 32'h18171615, 32'h1C1B1A19, 32'h201F1E1D};
        clear_got();
        @(posedge clk); #1;
        out_ready = 1'b1;
        load_seq(8'h11, 16);
        for (int i = 0; i < 300 && got_data.size() < 4; i++) @(negedge clk);
        n_checks++; if (got_data.size() != 4) begin n_fail++; $display("FAIL full_word_count: got %0d want 4", got_data.size()); end
        for (int k = 0; k < got_data.size() && k < 4; k++) begin
            n_checks++; if (got_data[k] !== exp_w[k]) begin n_fail++; $display("FAIL full_word%0d_data: got %h want %h", k, got_data[k], exp_w[k]); end
            n_checks++; if (got_bytes[k] !== 3'd4) begin n_fail++; $display("FAIL full_word%0d_bytes: got %0d want 4", k, got_bytes[k]); end
        end
        for (int k = 1; k < got_cyc.size(); k++) begin
            n_checks++; if (got_cyc[k] - got_cyc[k-1] != 6) begin n_fail++; $display("FAIL full_word_period%0d: got %0d want 6", k, got_cyc[k] - got_cyc[k-1]); end
        end
        repeat (3) @(negedge clk);
        n_checks++; if (words_out !== 16'd4) begin n_fail++; $display("FAIL full_words_out: got %0d want 4", words_out); end
        n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL full_fifo_empty: got %b want 1", fifo_empty); end
        n_checks++; if (underflow_cnt != 0) begin n_fail++; $display("FAIL full_underflow: got %0d want 0", underflow_cnt); end
    endtask

    task automatic test_backpressure();
        clear_got();
        @(posedge clk); #1;
        out_ready = 1'b0;
        load_seq(8'h40, 8);
        for (int i = 0; i < 50 && out_valid !== 1'b1; i++) @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== 32'h43424140) begin n_fail++; $display("FAIL bp_first_data: got %h want 43424140", out_data); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h43424140 || out_bytes !== 3'd4 || fifo_rd_en !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold cycle %0d: valid %b data %h bytes %0d rd_en %b want 1 43424140 4 0",
                                   i, out_valid, out_data, out_bytes, fifo_rd_en);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && got_data.size() < 2; i++) @(negedge clk);
        n_checks++; if (got_data.size() != 2) begin n_fail++; $display("FAIL bp_word_count: got %0d want 2", got_data.size()); end
        if (got_data.size() == 2) begin
            n_checks++; if (got_data[1] !== 32'h47464544) begin n_fail++; $display("FAIL bp_second_data: got %h want 47464544", got_data[1]); end
            n_checks++; if (got_cyc[1] - got_cyc[0] != 6) begin n_fail++; $display("FAIL bp_second_latency: got %0d want 6", got_cyc[1] - got_cyc[0]); end
        end
        repeat (2) @(negedge clk);
        n_checks++; if (words_out !== 16'd6) begin n_fail++; $display("FAIL bp_words_out: got %0d want 6", words_out); end
    endtask

    task automatic test_flush();
        int base;
        int seen;
        clear_got();
        base = rd_cnt;
        @(posedge clk); #1;
        out_ready = 1'b1;
        load_seq(8'h60, 6);
        // Pulse flush while the 6th byte is still landing.
        for (int i = 0; i < 50 && rd_cnt != base + 6; i++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 50 && got_data.size() < 2; i++) @(negedge clk);
        n_checks++; if (got_data.size() != 2) begin n_fail++; $display("FAIL flush_word_count: got %0d want 2", got_data.size()); end
        if (got_data.size() == 2) begin
            n_checks++; if (got_data[0] !== 32'h63626160) begin n_fail++; $display("FAIL flush_full_data: got %h want 63626160", got_data[0]); end
            n_checks++; if (got_bytes[0] !== 3'd4) begin n_fail++; $display("FAIL flush_full_bytes: got %0d want 4", got_bytes[0]); end
            n_checks++; if (got_data[1] !== 32'h00006564) begin n_fail++; $display("FAIL flush_tail_data: got %h want 00006564", got_data[1]); end
            n_checks++; if (got_bytes[1] !== 3'd2) begin n_fail++; $display("FAIL flush_tail_bytes: got %0d want 2", got_bytes[1]); end
        end
        repeat (3) @(negedge clk);
        n_checks++; if (words_out !== 16'd8) begin n_fail++; $display("FAIL flush_words_out: got %0d want 8", words_out); end
        seen = 0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0 || got_data.size() != 2) begin n_fail++; $display("FAIL empty_flush_output: valid cycles %0d words %0d want 0 2", seen, got_data.size()); end
        n_checks++; if (words_out !== 16'd8) begin n_fail++; $display("FAIL empty_flush_words_out: got %0d want 8", words_out); end
    endtask

    task automatic test_concurrent();
        int stable;
        int sum;
        int bad;
        logic [7:0]  got_q [$];
        logic [31:0] w;
        clear_got();
        exp_q.delete();
        conc_done = 1'b0;
        stable = 0;
        sum = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    #($urandom_range(5, 20));
                    if ($time % 10 == 5) #1;
                    src[wr_total] = 8'($urandom_range(0, 255));
                    exp_q.push_back(src[wr_total]);
                    wr_total++;
                end
                for (int i = 0; i < 500 && stable < 3; i++) begin
                    @(negedge clk);
                    if (fifo_empty && !out_valid && !fifo_rd_en && wr_taken == wr_total) stable++;
                    else stable = 0;
                end
                @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    sum = 0;
                    foreach (got_bytes[k]) sum += int'(got_bytes[k]);
                    if (sum >= 20 && !out_valid) break;
                end
                conc_done = 1'b1;
            end
            begin
                while (!conc_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < got_data.size(); k++) begin
            w = got_data[k];
            for (int b = 0; b < int'(got_bytes[k]) && b < 4; b++) got_q.push_back(w[8*b +: 8]);
        end
        n_checks++; if (stable < 3) begin n_fail++; $display("FAIL conc_idle_timeout: stable %0d want 3", stable); end
        n_checks++; if (sum != 20) begin n_fail++; $display("FAIL conc_byte_sum: got %0d want 20", sum); end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL conc_stream_len: got %0d want %0d", got_q.size(), exp_q.size()); end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                if (bad == 0) $display("FAIL conc_stream byte %0d: got %h want %h", i, got_q[i], exp_q[i]);
                bad++;
            end
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL conc_stream_total: %0d bytes differ, want 0", bad); end
        n_checks++; if (words_out !== 16'd13) begin n_fail++; $display("FAIL conc_words_out: got %0d want 13", words_out); end
        n_checks++; if (underflow_cnt != 0) begin n_fail++; $display("FAIL conc_underflow: got %0d want 0", underflow_cnt); end
    endtask

    task automatic test_reset_mid();
        int base;
        int seen;
        clear_got();
        @(posedge clk); #1;
        out_ready = 1'b0;
        load_seq(8'h80, 4);
        for (int i = 0; i < 50 && out_valid !== 1'b1; i++) @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_hold_reached: got %b want 1", out_valid); end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_hold_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rm_hold_data: got %h want 0", out_data); end
        n_checks++; if (out_bytes !== 3'd0) begin n_fail++; $display("FAIL rm_hold_bytes: got %0d want 0", out_bytes); end
        n_checks++; if (words_out !== 16'd0) begin n_fail++; $display("FAIL rm_hold_words_out: got %0d want 0", words_out); end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rm_hold_stale_word: valid cycles %0d want 0", seen); end

        base = rd_cnt;
        @(posedge clk); #1;
        load_seq(8'h90, 8);
        // Catch the third read issuing; reset then lands while that byte is in flight.
        for (int i = 0; i < 50 && !(rd_cnt == base + 2 && fifo_rd_en === 1'b1); i++) @(negedge clk);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_fail++; $display("FAIL rm_flight_outputs: valid %b data %h want 0 0", out_valid, out_data); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && got_data.size() < 1; i++) @(negedge clk);
        n_checks++; if (got_data.size() != 1) begin n_fail++; $display("FAIL rm_next_count: got %0d want 1", got_data.size()); end
        if (got_data.size() == 1) begin
            n_checks++; if (got_data[0] !== 32'h96959493) begin n_fail++; $display("FAIL rm_next_data: got %h want 96959493", got_data[0]); end
            n_checks++; if (got_bytes[0] !== 3'd4) begin n_fail++; $display("FAIL rm_next_bytes: got %0d want 4", got_bytes[0]); end
        end
        repeat (2) @(negedge clk);
        n_checks++; if (words_out !== 16'd1) begin n_fail++; $display("FAIL rm_words_out: got %0d want 1", words_out); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_words();
        test_backpressure();
        test_flush();
        test_concurrent();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
